// File: rtl/fuzzy_risk_engine.sv
// Two-input fuzzy risk estimator: triangular/shoulder membership, 9-rule min/max
// inference, weighted-singleton defuzzification by a bit-serial divider, hysteretic alarm.
module fuzzy_risk_engine #(
    parameter int W         = 8,
    parameter int RSH       = 4,
    parameter int C_LO      = 30,
    parameter int C_MED     = 50,
    parameter int C_HI      = 70,
    parameter int OUT_L     = 20,
    parameter int OUT_M     = 50,
    parameter int OUT_H     = 90,
    parameter int ALARM_ON  = 75,
    parameter int ALARM_OFF = 60
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_rain,
    input  logic [W-1:0] in_soil,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_risk,
    output logic         out_norule,
    output logic         out_alarm
);
    localparam int G  = 1 << RSH;
    localparam int GW = RSH + 1;
    localparam int DW = RSH + 3;
    localparam int NW = W + DW;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {IDLE, FUZZ, RULE, DIV, DONE} state_t;

    function automatic logic [GW-1:0] grade_low(input logic [W-1:0] x);
        int xi;
        xi = int'(x);
        if (xi <= C_LO) return GW'(G);
        if (xi < C_LO + G) return GW'(G - (xi - C_LO));
        return '0;
    endfunction

    function automatic logic [GW-1:0] grade_high(input logic [W-1:0] x);
        int xi;
        xi = int'(x);
        if (xi >= C_HI) return GW'(G);
        if (xi > C_HI - G) return GW'(G - (C_HI - xi));
        return '0;
    endfunction

    function automatic logic [GW-1:0] grade_med(input logic [W-1:0] x);
        int d;
        d = int'(x) - C_MED;
        if (d < 0) d = -d;
        if (d < G) return GW'(G - d);
        return '0;
    endfunction

    function automatic logic [GW-1:0] gmin(input logic [GW-1:0] a, input logic [GW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [GW-1:0] gmax(input logic [GW-1:0] a, input logic [GW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic alarm_next(input logic [W-1:0] r, input logic prev);
        if (int'(r) >= ALARM_ON) return 1'b1;
        if (int'(r) < ALARM_OFF) return 1'b0;
        return prev;
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    rain_q, rain_d, soil_q, soil_d;
    logic [GW-1:0]   lr_q, lr_d, mr_q, mr_d, hr_q, hr_d;
    logic [GW-1:0]   ls_q, ls_d, ms_q, ms_d, hs_q, hs_d;
    logic [NW-1:0]   num_q, num_d;
    logic [DW-1:0]   den_q, den_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    risk_q, risk_d;
    logic            norule_q, norule_d, alarm_q, alarm_d;

    logic [GW-1:0]   w_l, w_m, w_h;
    logic [NW-1:0]   num_rule;
    logic [DW-1:0]   den_rule;
    logic [DW:0]     trial;
    logic            ge;
    logic [DW-1:0]   rem_step;
    logic [W-1:0]    quo_step;

    // Rule base: a level is chosen by how "wet" the pair is overall
    always_comb begin
        w_l = gmax(gmax(gmin(lr_q, ls_q), gmin(lr_q, ms_q)), gmin(mr_q, ls_q));
        w_m = gmax(gmax(gmin(lr_q, hs_q), gmin(mr_q, ms_q)), gmin(hr_q, ls_q));
        w_h = gmax(gmax(gmin(mr_q, hs_q), gmin(hr_q, ms_q)), gmin(hr_q, hs_q));
        num_rule = NW'(w_l) * NW'(OUT_L) + NW'(w_m) * NW'(OUT_M) + NW'(w_h) * NW'(OUT_H);
        den_rule = DW'(w_l) + DW'(w_m) + DW'(w_h);
    end

    // Restoring division step; the remainder starts at num>>W, which is always < den
    always_comb begin
        trial    = {rem_q, quo_q[W-1]};
        ge       = (trial >= {1'b0, den_q});
        rem_step = ge ? (trial[DW-1:0] - den_q) : trial[DW-1:0];
        quo_step = {quo_q[W-2:0], ge};
    end

    always_comb begin
        state_d  = state_q;
        rain_d   = rain_q;
        soil_d   = soil_q;
        lr_d     = lr_q;
        mr_d     = mr_q;
        hr_d     = hr_q;
        ls_d     = ls_q;
        ms_d     = ms_q;
        hs_d     = hs_q;
        num_d    = num_q;
        den_d    = den_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        risk_d   = risk_q;
        norule_d = norule_q;
        alarm_d  = alarm_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rain_d  = in_rain;
                    soil_d  = in_soil;
                    state_d = FUZZ;
                end
            end
            FUZZ: begin
                lr_d    = grade_low(rain_q);
                mr_d    = grade_med(rain_q);
                hr_d    = grade_high(rain_q);
                ls_d    = grade_low(soil_q);
                ms_d    = grade_med(soil_q);
                hs_d    = grade_high(soil_q);
                state_d = RULE;
            end
            RULE: begin
                num_d = num_rule;
                den_d = den_rule;
                if (den_rule == '0) begin
                    risk_d   = '0;
                    norule_d = 1'b1;
                    alarm_d  = alarm_next('0, alarm_q);
                    state_d  = DONE;
                end else begin
                    norule_d = 1'b0;
                    rem_d    = num_rule[NW-1:W];
                    quo_d    = num_rule[W-1:0];
                    cnt_d    = '0;
                    state_d  = DIV;
                end
            end
            DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    risk_d  = quo_step;
                    alarm_d = alarm_next(quo_step, alarm_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rain_q   <= '0;
            soil_q   <= '0;
            lr_q     <= '0;
            mr_q     <= '0;
            hr_q     <= '0;
            ls_q     <= '0;
            ms_q     <= '0;
            hs_q     <= '0;
            num_q    <= '0;
            den_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            risk_q   <= '0;
            norule_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rain_q   <= rain_d;
            soil_q   <= soil_d;
            lr_q     <= lr_d;
            mr_q     <= mr_d;
            hr_q     <= hr_d;
            ls_q     <= ls_d;
            ms_q     <= ms_d;
            hs_q     <= hs_d;
            num_q    <= num_d;
            den_q    <= den_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            risk_q   <= risk_d;
            norule_q <= norule_d;
            alarm_q  <= alarm_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_risk   = risk_q;
    assign out_norule = norule_q;
    assign out_alarm  = alarm_q;

endmodule

// File: tb/tb_fuzzy_risk_engine.sv
// Bench for fuzzy_risk_engine: directed and random samples checked against a
// plain-arithmetic fuzzy model, plus a second instance with non-covering breakpoints.
module tb_fuzzy_risk_engine;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, out_norule, out_alarm;
    logic [W-1:0] in_rain, in_soil, out_risk;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_norule_b, out_alarm_b;
    logic [W-1:0] in_rain_b, in_soil_b, out_risk_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit expect_on;
    int exp_risk;
    bit exp_norule, exp_alarm, alarm_model, alarm_b;
    int obs_risk;
    bit obs_norule, obs_alarm;

    fuzzy_risk_engine #(.W(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rain(in_rain), .in_soil(in_soil),
        .out_valid(out_valid), .out_ready(out_ready), .out_risk(out_risk),
        .out_norule(out_norule), .out_alarm(out_alarm)
    );

    fuzzy_risk_engine #(.W(W), .RSH(2), .C_LO(10), .C_MED(100), .C_HI(200)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_rain(in_rain_b), .in_soil(in_soil_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_risk(out_risk_b),
        .out_norule(out_norule_b), .out_alarm(out_alarm_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int ramp(input int d, input int g);
        if (d <= 0) return g;
        if (d < g) return g - d;
        return 0;
    endfunction

    // Membership by distance from each fuzzy set's core; rule level from rain+soil rank
    function automatic void model(input int r, input int s, input int clo, input int cmed,
                                  input int chi, input int g, output int risk, output bit nr);
        int gr[3];
        int gs[3];
        int w[3];
        int num, den;
        gr[0] = ramp(r - clo, g);
        gr[1] = ramp((r > cmed) ? r - cmed : cmed - r, g);
        gr[2] = ramp(chi - r, g);
        gs[0] = ramp(s - clo, g);
        gs[1] = ramp((s > cmed) ? s - cmed : cmed - s, g);
        gs[2] = ramp(chi - s, g);
        w = '{0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int lv, st;
                lv = (i + j <= 1) ? 0 : ((i + j == 2) ? 1 : 2);
                st = (gr[i] < gs[j]) ? gr[i] : gs[j];
                if (st > w[lv]) w[lv] = st;
            end
        end
        num  = w[0] * 20 + w[1] * 50 + w[2] * 90;
        den  = w[0] + w[1] + w[2];
        nr   = (den == 0);
        risk = nr ? 0 : num / den;
    endfunction

    function automatic bit alarm_ref(input int risk, input bit prev);
        if (risk >= 75) return 1'b1;
        if (risk < 60) return 1'b0;
        return prev;
    endfunction

    // Every cycle a result is presented, it must be the one the model predicts
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            chk("valid_expected", int'(expect_on), 1);
            if (expect_on) begin
                chk("risk", int'(out_risk), exp_risk);
                chk("norule", int'(out_norule), int'(exp_norule));
                chk("alarm", int'(out_alarm), int'(exp_alarm));
                chk("in_ready_in_done", int'(in_ready), 0);
            end
        end
    end

    task automatic send(input int r, input int s, input int hold);
        int er;
        bit enr;
        int lat;
        model(r, s, 30, 50, 70, 16, er, enr);
        @(negedge clk);
        exp_risk    = er;
        exp_norule  = enr;
        exp_alarm   = alarm_ref(er, alarm_model);
        alarm_model = exp_alarm;
        expect_on   = 1'b1;
        in_rain     = 8'(r);
        in_soil     = 8'(s);
        in_valid    = 1'b1;
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            in_rain = 8'($urandom);
            in_soil = 8'($urandom);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, enr ? 2 : W + 2);
        obs_risk   = int'(out_risk);
        obs_norule = out_norule;
        obs_alarm  = out_alarm;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expect_on = 1'b0;
        chk("ret_idle_ready", int'(in_ready), 1);
        chk("ret_idle_valid", int'(out_valid), 0);
    endtask

    task automatic send_b(input int r, input int s);
        int er;
        bit enr, ea;
        int lat;
        model(r, s, 10, 100, 200, 4, er, enr);
        ea      = alarm_ref(er, alarm_b);
        alarm_b = ea;
        @(negedge clk);
        in_rain_b  = 8'(r);
        in_soil_b  = 8'(s);
        in_valid_b = 1'b1;
        chk("b_in_ready_idle", int'(in_ready_b), 1);
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid_b) begin
                lat = k;
                break;
            end
        end
        chk("b_latency", lat, enr ? 2 : W + 2);
        chk("b_risk", int'(out_risk_b), er);
        chk("b_norule", int'(out_norule_b), int'(enr));
        chk("b_alarm", int'(out_alarm_b), int'(ea));
        @(negedge clk);
        out_ready_b = 1'b1;
        @(posedge clk);
        #1;
        out_ready_b = 1'b0;
        chk("b_ret_idle", int'(in_ready_b), 1);
    endtask

    initial begin
        int mr;
        bit mn;
        rst_n = 1'b0;
        in_valid = 1'b0;  out_ready = 1'b0;  in_rain = '0;  in_soil = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; in_rain_b = '0; in_soil_b = '0;
        expect_on = 1'b0; alarm_model = 1'b0; alarm_b = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_risk", int'(out_risk), 0);
        chk("rst_out_norule", int'(out_norule), 0);
        chk("rst_out_alarm", int'(out_alarm), 0);
        chk("rst_b_in_ready", int'(in_ready_b), 1);
        @(negedge clk);
        rst_n = 1'b1;

        model(40, 50, 30, 50, 70, 16, mr, mn);  chk("model_40_50", mr, 35);
        model(10, 10, 30, 50, 70, 16, mr, mn);  chk("model_10_10", mr, 20);
        model(50, 90, 30, 50, 70, 16, mr, mn);  chk("model_50_90", mr, 90);
        model(50, 50, 30, 50, 70, 16, mr, mn);  chk("model_50_50", mr, 50);
        model(50, 7, 10, 100, 200, 4, mr, mn);  chk("model_b_norule", int'(mn), 1);

        send(10, 10, 0);
        chk("d_10_10_risk", obs_risk, 20);
        chk("d_10_10_norule", int'(obs_norule), 0);
        chk("d_10_10_alarm", int'(obs_alarm), 0);
        send(40, 50, 1);
        chk("d_40_50_risk", obs_risk, 35);
        send(90, 90, 0);
        chk("hyst1_risk", obs_risk, 90);
        chk("hyst1_alarm", int'(obs_alarm), 1);
        send(50, 90, 2);
        chk("hyst2_risk", obs_risk, 90);
        chk("hyst2_alarm", int'(obs_alarm), 1);
        send(50, 50, 0);
        chk("hyst3_risk", obs_risk, 50);
        chk("hyst3_alarm", int'(obs_alarm), 0);
        send(30, 30, 0);
        chk("bp_lo_risk", obs_risk, 20);
        send(70, 70, 0);
        chk("bp_hi_risk", obs_risk, 90);
        send(70, 30, 20);
        chk("backpressure_risk", obs_risk, 50);

        for (int n = 0; n < 60; n++) begin
            int r, s;
            r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 110);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 110);
            send(r, s, $urandom_range(0, 3));
        end

        // Reset while the divider is busy; alarm is known high beforehand
        send(90, 90, 0);
        @(negedge clk);
        in_rain = 8'd90; in_soil = 8'd90; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        expect_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_risk", int'(out_risk), 0);
        chk("midrst_out_alarm", int'(out_alarm), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_hold_valid", int'(out_valid), 0);
        end
        rst_n = 1'b1;
        alarm_model = 1'b0;
        alarm_b = 1'b0;
        send(40, 50, 0);
        chk("postrst_risk", obs_risk, 35);
        chk("postrst_alarm", int'(obs_alarm), 0);

        send_b(50, int'($urandom_range(0, 255)));
        send_b(100, 100);
        send_b(12, 12);
        send_b(199, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
